// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32 fetch/run-control slice.
//   state_e       : run/halt state machine encoding
//   halt_cause_e  : reason code reported on halt_cause
//   EbreakInsn    : encoding of the ebreak instruction
//   is_word_aligned() : true when the low two address bits are zero
// -----------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StExec  = 2'd2,
      StHalt  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      CauseReq      = 2'd0,
      CauseBp       = 2'd1,
      CauseEbreak   = 2'd2,
      CauseMisalign = 2'd3
   } halt_cause_e;

   localparam logic [31:0] EbreakInsn = 32'h0010_0073;

   // Only the two least-significant bits of an address decide word alignment.
   function automatic logic is_word_aligned(input logic [1:0] lsbs);
      return (lsbs == 2'b00);
   endfunction

endpackage

// File: rtl/riscv_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// riscv_fetch_ctrl_if
// Bundles the program-load bus and the datapath instruction handshake.
//   load_we/load_addr/load_data : instruction-memory write from the host
//   load_err                    : one-cycle pulse, write was rejected
//   instr/pc/instr_valid        : instruction presented to the datapath
//   next_pc                     : datapath's computed next PC
// Modports:
//   master : host + datapath side (drives load bus and next_pc)
//   slave  : fetch controller side
// -----------------------------------------------------------------------------
interface riscv_fetch_ctrl_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned IMEM_AW = 8
);

   logic               load_we;
   logic [IMEM_AW-1:0] load_addr;
   logic [31:0]        load_data;
   logic               load_err;

   logic [31:0]        instr;
   logic [XLEN-1:0]    pc;
   logic               instr_valid;
   logic [XLEN-1:0]    next_pc;

   modport master (
      output load_we,
      output load_addr,
      output load_data,
      input  load_err,
      input  instr,
      input  pc,
      input  instr_valid,
      output next_pc
   );

   modport slave (
      input  load_we,
      input  load_addr,
      input  load_data,
      output load_err,
      output instr,
      output pc,
      output instr_valid,
      input  next_pc
   );

endinterface

// File: rtl/riscv_imem.sv
// -----------------------------------------------------------------------------
// riscv_imem
// Instruction memory: 2**AW words of DW bits, one write port and one
// synchronous read port. Contents are not reset.
//   clk   : clock
//   we    : write strobe
//   waddr : write word address
//   wdata : write data
//   re    : read enable; rdata updates on the next clock edge
//   raddr : read word address
//   rdata : registered read data, holds while re is low
// -----------------------------------------------------------------------------
module riscv_imem #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int unsigned Depth = 2 ** AW;

   logic [DW-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_fetch_ctrl
// Program-load, fetch and run-control for the RV32 cores. Owns the
// instruction memory, the PC and the IDLE/FETCH/EXEC/HALT state machine and
// presents one instruction every two cycles to the datapath.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : load bus + datapath handshake (slave modport)
//   run         : pulse, start/resume free run
//   step        : pulse, run exactly one instruction (wins over run)
//   halt_req    : pulse, stop at the next instruction boundary
//   bp_en       : breakpoint enable
//   bp_addr     : breakpoint byte address
//   halted      : state is HALT
//   halt_cause  : 0 request, 1 breakpoint, 2 ebreak, 3 misaligned next_pc
//   retired     : committed-instruction count, wraps
// -----------------------------------------------------------------------------
module riscv_fetch_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     IMEM_AW     = 8,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter bit              EBREAK_HALT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   riscv_fetch_ctrl_if.slave bus,
   input  logic              run,
   input  logic              step,
   input  logic              halt_req,
   input  logic              bp_en,
   input  logic [XLEN-1:0]   bp_addr,
   output logic              halted,
   output logic [1:0]        halt_cause,
   output logic [31:0]       retired
);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [31:0]       retired_q, retired_d;
   halt_cause_e       cause_q, cause_d;
   logic              step_q, step_d;
   logic              skip_bp_q, skip_bp_d;
   logic              halt_pend_q, halt_pend_d;
   logic              load_err_q;

   logic              load_ok;
   logic              mem_we;
   logic              mem_re;
   logic [31:0]       mem_rdata;
   logic              halt_pend_any;
   logic              bp_hit;
   logic              is_ebreak;

   // Loads are only safe while nothing is being fetched.
   assign load_ok = (state_q == StIdle) || (state_q == StHalt);
   assign mem_we  = bus.load_we && load_ok;
   assign mem_re  = (state_q == StFetch);

   riscv_imem #(
      .AW (IMEM_AW),
      .DW (32)
   ) u_imem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (bus.load_addr),
      .wdata (bus.load_data),
      .re    (mem_re),
      .raddr (pc_q[IMEM_AW+1:2]),
      .rdata (mem_rdata)
   );

   // A request arriving in the same cycle as the FETCH it should stop counts.
   assign halt_pend_any = halt_pend_q || halt_req;
   assign bp_hit        = bp_en && (pc_q == bp_addr) && !skip_bp_q;
   assign is_ebreak     = EBREAK_HALT && (mem_rdata == EbreakInsn);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      retired_d   = retired_q;
      cause_d     = cause_q;
      step_d      = step_q;
      skip_bp_d   = skip_bp_q;
      halt_pend_d = halt_pend_any;

      unique case (state_q)
         StIdle: begin
            if (step) begin
               state_d   = StFetch;
               step_d    = 1'b1;
               skip_bp_d = 1'b0;
            end else if (run) begin
               state_d   = StFetch;
               step_d    = 1'b0;
               skip_bp_d = 1'b0;
            end
         end

         StFetch: begin
            if (halt_pend_any) begin
               state_d = StHalt;
               cause_d = CauseReq;
            end else if (bp_hit) begin
               state_d = StHalt;
               cause_d = CauseBp;
            end else begin
               state_d   = StExec;
               skip_bp_d = 1'b0;
            end
         end

         StExec: begin
            if (is_ebreak) begin
               // ebreak is shown to the datapath but never committed.
               state_d = StHalt;
               cause_d = CauseEbreak;
            end else if (!is_word_aligned(bus.next_pc[1:0])) begin
               // Instruction commits, but the bad target is not taken.
               state_d   = StHalt;
               cause_d   = CauseMisalign;
               retired_d = retired_q + 32'd1;
            end else begin
               pc_d      = bus.next_pc;
               retired_d = retired_q + 32'd1;
               if (step_q) begin
                  state_d = StHalt;
                  cause_d = CauseReq;
               end else begin
                  state_d = StFetch;
               end
            end
         end

         StHalt: begin
            // A stop request alongside a resume keeps the core parked.
            if (!halt_req) begin
               if (step) begin
                  state_d   = StFetch;
                  step_d    = 1'b1;
                  skip_bp_d = 1'b1;
               end else if (run) begin
                  state_d   = StFetch;
                  step_d    = 1'b0;
                  skip_bp_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if ((state_d == StHalt) || (state_d == StIdle)) begin
         halt_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         retired_q   <= '0;
         cause_q     <= CauseReq;
         step_q      <= 1'b0;
         skip_bp_q   <= 1'b0;
         halt_pend_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         retired_q   <= retired_d;
         cause_q     <= cause_d;
         step_q      <= step_d;
         skip_bp_q   <= skip_bp_d;
         halt_pend_q <= halt_pend_d;
         load_err_q  <= bus.load_we && !load_ok;
      end
   end

   assign bus.instr       = mem_rdata;
   assign bus.pc          = pc_q;
   // Reset suppresses the commit of an in-flight instruction at once.
   assign bus.instr_valid = (state_q == StExec) && !reset;
   assign bus.load_err    = load_err_q;

   assign halted     = (state_q == StHalt);
   assign halt_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_ctrl
// Scoreboarded bench: every expected (pc, instr, cycle) is queued when the
// run/step stimulus is issued and checked when instr_valid appears.
// A second small instance (IMEM_AW=2) covers memory-index wrap.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_ctrl;
   import riscv_pkg::*;

   localparam logic [31:0] Nop = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          rel;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        run, step, halt_req, bp_en;
   logic [31:0] bp_addr;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [31:0] retired;
   logic [31:0] np_offs;

   logic        run2, halt_req2, halted2;
   logic [1:0]  halt_cause2;
   logic [31:0] retired2;
   logic [31:0] w2 [4];
   bit          hit2;

   int          cyc = 0;
   int          t_run = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        sb[$];
   exp_t        sb2[$];
   exp_t        e1, e2;

   riscv_fetch_ctrl_if #(.XLEN(32), .IMEM_AW(8)) bus ();
   riscv_fetch_ctrl_if #(.XLEN(32), .IMEM_AW(2)) bus2 ();

   assign bus.next_pc  = bus.pc + np_offs;
   assign bus2.next_pc = bus2.pc + 32'd4;

   riscv_fetch_ctrl #(
      .XLEN        (32),
      .IMEM_AW     (8),
      .RESET_PC    (32'd0),
      .EBREAK_HALT (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .run        (run),
      .step       (step),
      .halt_req   (halt_req),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .halted     (halted),
      .halt_cause (halt_cause),
      .retired    (retired)
   );

   riscv_fetch_ctrl #(
      .XLEN        (32),
      .IMEM_AW     (2),
      .RESET_PC    (32'd0),
      .EBREAK_HALT (1'b1)
   ) dut2 (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus2.slave),
      .run        (run2),
      .step       (1'b0),
      .halt_req   (halt_req2),
      .bp_en      (1'b0),
      .bp_addr    (32'd0),
      .halted     (halted2),
      .halt_cause (halt_cause2),
      .retired    (retired2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] ins, input int rel);
      exp_t e;
      e.pc    = p;
      e.instr = ins;
      e.rel   = rel;
      sb.push_back(e);
   endtask

   task automatic push2(input logic [31:0] p, input logic [31:0] ins, input int rel);
      exp_t e;
      e.pc    = p;
      e.instr = ins;
      e.rel   = rel;
      sb2.push_back(e);
   endtask

   // Scoreboard side: every instr_valid must match the oldest queued entry.
   always @(negedge clk) begin
      if (bus.instr_valid === 1'b1) begin
         check_eq("valid_expected", 32'(bus.instr_valid), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            e1 = sb.pop_front();
            check_eq("sb_pc", bus.pc, e1.pc);
            check_eq("sb_instr", bus.instr, e1.instr);
            if (e1.rel >= 0) check_eq("sb_cycle", 32'(cyc - t_run), 32'(e1.rel));
         end
      end
   end

   always @(negedge clk) begin
      if (bus2.instr_valid === 1'b1) begin
         check_eq("valid2_expected", 32'(bus2.instr_valid), 32'(sb2.size() != 0));
         if (sb2.size() != 0) begin
            e2 = sb2.pop_front();
            check_eq("sb2_pc", bus2.pc, e2.pc);
            check_eq("sb2_instr", bus2.instr, e2.instr);
            check_eq("sb2_cycle", 32'(cyc - t_run), 32'(e2.rel));
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic load_word(input logic [7:0] a, input logic [31:0] d);
      bus.load_we   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      tick();
      bus.load_we   = 1'b0;
   endtask

   task automatic start(input bit do_step, input bit ld = 1'b0,
                        input logic [7:0] a = '0, input logic [31:0] d = '0);
      if (do_step) step = 1'b1;
      else run = 1'b1;
      bus.load_we   = ld;
      bus.load_addr = a;
      bus.load_data = d;
      t_run = cyc;
      tick();
      run         = 1'b0;
      step        = 1'b0;
      bus.load_we = 1'b0;
   endtask

   task automatic wait_halt();
      bit seen_run;
      bit hit;
      seen_run = !halted;
      hit      = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(negedge clk);
         if (!halted) seen_run = 1'b1;
         else if (seen_run) hit = 1'b1;
      end
      check_eq("halt_reached", 32'(hit), 32'd1);
   endtask

   // Free run of n instructions; the stop request lands in the n-th EXEC.
   task automatic run_n(input int n, input bit ld = 1'b0,
                        input logic [7:0] a = '0, input logic [31:0] d = '0);
      start(1'b0, ld, a, d);
      repeat (2 * n - 1) tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      wait_halt();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
      bp_en = 1'b0; bp_addr = '0; np_offs = 32'd4;
      run2 = 1'b0; halt_req2 = 1'b0;
      bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;
      bus2.load_we = 1'b0; bus2.load_addr = '0; bus2.load_data = '0;
      w2[0] = 32'h0000_0013; w2[1] = 32'h0010_0093;
      w2[2] = 32'h0020_0113; w2[3] = 32'h0030_0193;

      do_reset();
      @(negedge clk);
      check_eq("rst_pc", bus.pc, 32'd0);
      check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
      check_eq("rst_halted", 32'(halted), 32'd0);
      check_eq("rst_cause", 32'(halt_cause), 32'd0);
      check_eq("rst_retired", retired, 32'd0);
      check_eq("rst_load_err", 32'(bus.load_err), 32'd0);
      tick();

      // Four nops at two cycles each, then stop.
      for (int i = 0; i < 4; i++) load_word(8'(i), Nop);
      for (int i = 0; i < 4; i++) push(32'(4 * i), Nop, 2 * i + 2);
      run_n(4);
      check_eq("run4_retired", retired, 32'd4);
      check_eq("run4_pc", bus.pc, 32'd16);
      check_eq("run4_cause", 32'(halt_cause), 32'(CauseReq));

      // Breakpoint at 8, then step off it.
      do_reset();
      bp_en = 1'b1; bp_addr = 32'd8;
      push(32'd0, Nop, 2);
      push(32'd4, Nop, 4);
      start(1'b0);
      wait_halt();
      check_eq("bp_cause", 32'(halt_cause), 32'(CauseBp));
      check_eq("bp_pc", bus.pc, 32'd8);
      check_eq("bp_retired", retired, 32'd2);
      push(32'd8, Nop, 2);
      start(1'b1);
      wait_halt();
      check_eq("step_pc", bus.pc, 32'd12);
      check_eq("step_retired", retired, 32'd3);
      check_eq("step_cause", 32'(halt_cause), 32'(CauseReq));
      bp_en = 1'b0;

      // ebreak halts without retiring; then a misaligned target.
      do_reset();
      load_word(8'd1, EbreakInsn);
      push(32'd0, Nop, 2);
      push(32'd4, EbreakInsn, 4);
      start(1'b0);
      wait_halt();
      check_eq("ebrk_cause", 32'(halt_cause), 32'(CauseEbreak));
      check_eq("ebrk_pc", bus.pc, 32'd4);
      check_eq("ebrk_retired", retired, 32'd1);
      load_word(8'd1, Nop);
      @(negedge clk);
      check_eq("halt_load_err", 32'(bus.load_err), 32'd0);
      np_offs = 32'd2;
      push(32'd4, Nop, 2);
      start(1'b0);
      wait_halt();
      check_eq("mis_cause", 32'(halt_cause), 32'(CauseMisalign));
      check_eq("mis_pc", bus.pc, 32'd4);
      check_eq("mis_retired", retired, 32'd2);
      np_offs = 32'd4;

      // Reset while an instruction sits in EXEC.
      start(1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check_eq("rexec_valid", 32'(bus.instr_valid), 32'd0);
      check_eq("rexec_pc", bus.pc, 32'd0);
      check_eq("rexec_retired", retired, 32'd0);
      check_eq("rexec_halted", 32'(halted), 32'd0);
      check_eq("rexec_cause", 32'(halt_cause), 32'd0);
      tick();

      // Load during FETCH is rejected and flagged for one cycle.
      push(32'd0, Nop, 2);
      start(1'b0);
      bus.load_we = 1'b1; bus.load_addr = 8'd0; bus.load_data = 32'hDEAD_BEEF;
      tick();
      bus.load_we = 1'b0;
      halt_req = 1'b1;
      @(negedge clk);
      check_eq("load_err_set", 32'(bus.load_err), 32'd1);
      tick();
      halt_req = 1'b0;
      @(negedge clk);
      check_eq("load_err_pulse", 32'(bus.load_err), 32'd0);
      wait_halt();
      check_eq("lerr_pc", bus.pc, 32'd4);
      check_eq("lerr_retired", retired, 32'd1);

      // halt_req together with run keeps the core halted.
      tick();
      run = 1'b1; halt_req = 1'b1;
      tick();
      run = 1'b0; halt_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("stay_halted", 32'(halted), 32'd1);
         check_eq("stay_pc", bus.pc, 32'd4);
      end

      // Word 0 still holds the nop after reset and the rejected write.
      do_reset();
      push(32'd0, Nop, 2);
      run_n(1);
      check_eq("intact_retired", retired, 32'd1);
      check_eq("intact_pc", bus.pc, 32'd4);

      // Load and run in the same IDLE cycle: the fetch sees the new word.
      do_reset();
      push(32'd0, 32'h0050_0093, 2);
      run_n(1, 1'b1, 8'd0, 32'h0050_0093);
      check_eq("ldrun_retired", retired, 32'd1);

      // Depth-4 memory: the fifth fetch at pc 16 reads word 0.
      tick();
      for (int i = 0; i < 4; i++) begin
         bus2.load_we = 1'b1; bus2.load_addr = 2'(i); bus2.load_data = w2[i];
         tick();
      end
      bus2.load_we = 1'b0;
      for (int i = 0; i < 5; i++) push2(32'(4 * i), w2[i % 4], 2 * i + 2);
      run2 = 1'b1;
      t_run = cyc;
      tick();
      run2 = 1'b0;
      repeat (9) tick();
      halt_req2 = 1'b1;
      tick();
      halt_req2 = 1'b0;
      hit2 = 1'b0;
      for (int k = 0; k < 40 && !hit2; k++) begin
         @(negedge clk);
         hit2 = halted2;
      end
      check_eq("wrap_halted", 32'(hit2), 32'd1);
      check_eq("wrap_pc", bus2.pc, 32'd20);
      check_eq("wrap_retired", retired2, 32'd5);

      repeat (2) tick();
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      check_eq("sb2_drain", 32'(sb2.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
